// File: rtl/arm_defs.sv
// Shared constants and helpers for the fetch front end.
package arm_defs;

    localparam int WORD_W   = 32;
    localparam int FQ_DEPTH = 4;
    localparam int DROP_W   = 16;

    function automatic logic [DROP_W-1:0] sat_add16(
        input logic [DROP_W-1:0] a,
        input logic [DROP_W-1:0] b
    );
        logic [DROP_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DROP_W] ? {DROP_W{1'b1}} : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Queue storage: one write port, asynchronous read, no reset.
module fetch_queue_mem
    import arm_defs::*;
#(
    parameter int WIDTH = 2 * WORD_W,
    parameter int DEPTH = FQ_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between fetch and decode, with flush-drop accounting.
module fetch_queue
    import arm_defs::*;
#(
    parameter int DATA_W = WORD_W,
    parameter int PC_W   = WORD_W,
    parameter int DEPTH  = FQ_DEPTH,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [PC_W-1:0]   in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              in_ready,
    input  logic              freeze,
    input  logic              flush,
    output logic              out_valid,
    output logic [PC_W-1:0]   out_pc,
    output logic [DATA_W-1:0] out_instr,
    output logic [CNT_W-1:0]  count,
    output logic [15:0]       drop_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int EW = PC_W + DATA_W;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [EW-1:0] rd_data;
    logic          full;
    logic          push;
    logic          pop;

    assign full      = (count == CNT_W'(DEPTH));
    assign in_ready  = !full;
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && !freeze;

    // Stale slot data never leaks: head is masked while empty.
    assign out_pc    = out_valid ? rd_data[EW-1 -: PC_W] : '0;
    assign out_instr = out_valid ? rd_data[DATA_W-1:0] : '0;

    fetch_queue_mem #(
        .WIDTH (EW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push && !flush),
        .waddr (wr_ptr),
        .wdata ({in_pc, in_instr}),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            drop_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            if (count != '0) begin
                drop_cnt <= sat_add16(drop_cnt, 16'(count));
            end
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter DATA_W, default 32: instruction width in bits.
REQ-002 SHALL have parameter PC_W, default 32: PC width in bits.
REQ-003 SHALL have parameter DEPTH, default 4: entry count; legal values are a power of two and at least 2.
REQ-004 SHALL have parameter CNT_W, default $clog2(DEPTH)+1: occupancy counter width.
REQ-005 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, 1: fetch side presents an entry.
REQ-008 SHALL have port in_pc, input, PC_W: PC of the fetched instruction.
REQ-009 SHALL have port in_instr, input, DATA_W: fetched instruction.
REQ-010 SHALL have port in_ready, output, 1: queue accepts a push this cycle.
REQ-011 SHALL have port freeze, input, 1: decode stalled; no pop.
REQ-012 SHALL have port flush, input, 1: branch taken; discard all contents.
REQ-013 SHALL have port out_valid, output, 1: head entry is valid.
REQ-014 SHALL have ports out_pc (PC_W) and out_instr (DATA_W), output: head entry.
REQ-015 SHALL have port count, output, CNT_W: current occupancy, 0..DEPTH.
REQ-016 SHALL have port drop_cnt, output, 16: saturating total of entries discarded by flushes.

Function
REQ-017 A push SHALL occur when in_valid && in_ready; a pop SHALL occur when out_valid && !freeze.
REQ-018 in_ready SHALL be !full (count==DEPTH is full); it SHALL NOT depend combinationally on freeze or flush.
REQ-019 out_valid SHALL be (count!=0); out_pc/out_instr SHALL reflect the entry at the read pointer.
REQ-020 Ordering SHALL be strict FIFO; a pushed entry SHALL first appear at the outputs on the cycle after the push (1-cycle latency, no fall-through).
REQ-021 Read and write pointers SHALL be $clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-022 Push and pop in the same cycle SHALL advance both pointers and leave count unchanged, including when count==DEPTH-1 or 1.
REQ-023 When full, a push is not possible; a same-cycle pop SHALL free exactly one slot, visible as in_ready=1 on the next cycle.
REQ-024 When empty, freeze SHALL have no effect and count SHALL NOT underflow.
REQ-025 flush SHALL take priority over push and pop: next cycle count=0, both pointers=0, out_valid=0, and any same-cycle push discarded.
REQ-026 On flush, drop_cnt SHALL add the pre-flush count (same-cycle push excluded), saturating at 16'hFFFF.
REQ-027 flush while empty SHALL leave drop_cnt unchanged.
REQ-028 Storage contents SHALL NOT affect any output while the corresponding slot is invalid.

Reset
REQ-029 rst SHALL asynchronously clear pointers, count, and drop_cnt to 0, forcing out_valid=0 and in_ready=1.
REQ-030 Storage array contents SHALL NOT require reset.
REQ-031 Reset asserted mid-operation SHALL discard all entries without incrementing drop_cnt.

Structure
REQ-032 The shared package arm_defs SHALL hold WORD_W=32 and the default queue depth constant; fetch_queue SHALL take its defaults from it.
REQ-033 Storage SHALL be a sub-module fetch_queue_mem (DEPTH x (PC_W+DATA_W), one write port, one asynchronous read port, no reset).
REQ-034 Control (pointers, count, drop_cnt) SHALL reside in fetch_queue.

Verification
REQ-035 Reset, then push PC 0,4,8,12 (DEPTH=4) with freeze=1 -> count=4, in_ready=0, out_pc=0.
REQ-036 When full, release freeze and hold in_valid -> pop and push overlap; out_pc sequence 0,4,8,12,16… with no gaps; count stays at 3 or 4 as required by REQ-023.
REQ-037 Wrap: stream 10 entries through DEPTH=4 with alternating freeze -> output order matches input order, with no loss or duplication.
REQ-038 With 3 entries, assert flush with a same-cycle push -> next cycle count=0, out_valid=0, drop_cnt=3; the pushed PC never appears at the output.
REQ-039 Preload drop_cnt to 16'hFFFE via flushes, then flush 3 entries -> drop_cnt=16'hFFFF.
REQ-040 Assert rst asynchronously mid-stream with count=2 -> outputs clear before the next clock edge, drop_cnt=0.
